// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, 2-entry
// instruction queue toward decode, and branch redirect with in-flight discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus4
);

    localparam logic [1:0] LP_DEPTH = DEPTH[1:0];

    typedef enum logic {ST_FETCH, ST_DISCARD} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_addr;
    logic        r_pending;
    logic [1:0]  r_count;
    logic [31:0] r_q_pc    [2];
    logic [31:0] r_q_instr [2];

    logic        w_req;
    logic        w_ack;
    logic        w_pop;
    logic        w_push;
    logic        w_wr_idx;
    logic [31:0] w_target;

    // A raised request is held (r_pending) until acked, so count+outstanding
    // only needs checking when nothing is outstanding.
    assign w_req     = !reset && (r_pending || (r_state == ST_FETCH && r_count < LP_DEPTH));
    assign imem_req  = w_req;
    assign imem_addr = r_pending ? r_req_addr : r_fetch_pc;

    assign w_ack    = imem_ack && w_req;
    assign id_valid = (r_count != 2'd0);
    assign w_pop    = id_valid && id_ready;
    assign w_push   = w_ack && (r_state == ST_FETCH) && !Branch_taken;
    assign w_target = {Branch_target[31:2], 2'b00};
    assign w_wr_idx = (r_count != 2'd0) && !w_pop;

    assign Instr    = r_q_instr[0];
    assign Opcode   = r_q_instr[0][31:26];
    assign PC_out   = r_q_pc[0];
    assign PC_plus4 = r_q_pc[0] + 32'd4;

    always_comb begin
        w_state_next = r_state;
        if (Branch_taken) begin
            w_state_next = (w_req && !imem_ack) ? ST_DISCARD : ST_FETCH;
        end else if (r_state == ST_DISCARD && w_ack) begin
            w_state_next = ST_FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_pending  <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (Branch_taken) begin
                // The old request stays on the bus until its ack is swallowed.
                r_fetch_pc <= w_target;
                r_count    <= 2'd0;
                r_pending  <= w_req && !imem_ack;
                r_req_addr <= imem_addr;
            end else begin
                if (w_ack) begin
                    r_pending <= 1'b0;
                end else if (w_req) begin
                    r_pending  <= 1'b1;
                    r_req_addr <= imem_addr;
                end
                if (w_push) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_q_pc[i]    <= 32'd0;
                r_q_instr[i] <= 32'd0;
            end
        end else if (!Branch_taken) begin
            if (w_pop) begin
                r_q_pc[0]    <= r_q_pc[1];
                r_q_instr[0] <= r_q_instr[1];
            end
            if (w_push) begin
                r_q_pc[w_wr_idx]    <= imem_addr;
                r_q_instr[w_wr_idx] <= imem_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        Branch_taken = 1'b0;
    logic [31:0] Branch_target = 32'd0;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic [31:0] PC_out;
    logic [31:0] PC_plus4;

    int   lat = 0;
    int   wcnt = 0;
    logic mem_auto = 1'b1;
    logic mem_mode = 1'b0;
    logic force_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .Branch_taken (Branch_taken),
        .Branch_target(Branch_target),
        .id_ready     (id_ready),
        .id_valid     (id_valid),
        .Instr        (Instr),
        .Opcode       (Opcode),
        .PC_out       (PC_out),
        .PC_plus4     (PC_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic mode);
        if (mode && a == 32'h200) return 32'h2008_0005;
        if (mode && a == 32'h204) return 32'h8C08_0004;
        return a + 32'h1000;
    endfunction

    always_comb begin
        imem_ack  = force_ack || (mem_auto && imem_req && (wcnt >= lat));
        imem_data = force_ack ? 32'hDEAD_BEEF : mem_word(imem_addr, mem_mode);
    end

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_req_addr(input string tag, input logic [31:0] a);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, imem_req && imem_addr == a}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!id_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, id_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic [31:0] e;

        // Reset values and zero-wait streaming
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", Instr, 32'd0);
        chk("rst_opcode", {26'd0, Opcode}, 32'd0);
        chk("rst_pc", PC_out, 32'd0);
        chk("rst_pc4", PC_plus4, 32'd4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("s_req0", {31'd0, imem_req}, 32'd1);
        chk("s_addr0", imem_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = 32'(i) * 32'd4;
            chk("s_instr", Instr, e + 32'h1000);
            chk("s_pc", PC_out, e);
            chk("s_pc4", PC_plus4, e + 32'd4);
            chk("s_addr", imem_addr, e + 32'd4);
        end

        // Backpressure: two acks fill the queue, then drain in order
        id_ready = 1'b0;
        do_reset();
        acks = 0;
        if (imem_ack) acks++;
        repeat (5) begin
            @(negedge clk);
            if (imem_ack) acks++;
        end
        chk("bp_acks", 32'(acks), 32'd2);
        chk("bp_req", {31'd0, imem_req}, 32'd0);
        chk("bp_head", Instr, 32'h1000);
        id_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain1", Instr, 32'h1004);
        chk("bp_drain1_pc", PC_out, 32'h4);
        chk("bp_resume_addr", imem_addr, 32'h8);
        chk("bp_resume_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        chk("bp_drain2", Instr, 32'h1008);
        chk("bp_drain2_pc", PC_out, 32'h8);

        // Latency 3, redirect while request to 0x8 is in flight
        lat = 3;
        do_reset();
        wait_req_addr("lat_req8", 32'h8);
        @(negedge clk);
        Branch_taken = 1'b1;
        Branch_target = 32'h40;
        @(negedge clk);
        Branch_taken = 1'b0;
        chk("lat_hold_addr", imem_addr, 32'h8);
        chk("lat_hold_req", {31'd0, imem_req}, 32'd1);
        chk("lat_valid", {31'd0, id_valid}, 32'd0);
        wait_req_addr("lat_req40", 32'h40);
        chk("lat_valid2", {31'd0, id_valid}, 32'd0);
        wait_valid("lat_deliver");
        chk("lat_pc", PC_out, 32'h40);
        chk("lat_instr", Instr, 32'h1040);

        // Redirect in the same cycle as the ack for 0xC
        lat = 0;
        do_reset();
        wait_req_addr("same_reqC", 32'hC);
        Branch_taken = 1'b1;
        Branch_target = 32'h100;
        @(negedge clk);
        Branch_taken = 1'b0;
        chk("same_valid", {31'd0, id_valid}, 32'd0);
        chk("same_addr", imem_addr, 32'h100);
        chk("same_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        chk("same_pc", PC_out, 32'h100);
        chk("same_instr", Instr, 32'h1100);
        chk("same_pc4", PC_plus4, 32'h104);

        // Opcode field of queued addi then lw
        id_ready = 1'b0;
        mem_mode = 1'b1;
        Branch_taken = 1'b1;
        Branch_target = 32'h200;
        @(negedge clk);
        Branch_taken = 1'b0;
        begin
            int n = 0;
            while (imem_req && n < 30) begin
                @(negedge clk);
                n++;
            end
        end
        chk("op_full", {31'd0, imem_req}, 32'd0);
        chk("op_valid", {31'd0, id_valid}, 32'd1);
        chk("op_addi", {26'd0, Opcode}, 32'h08);
        chk("op_addi_pc", PC_out, 32'h200);
        chk("op_addi_instr", Instr, 32'h2008_0005);
        id_ready = 1'b1;
        @(negedge clk);
        chk("op_lw", {26'd0, Opcode}, 32'h23);
        chk("op_lw_pc", PC_out, 32'h204);

        // Double redirect during discard, second target unaligned
        mem_mode = 1'b0;
        lat = 3;
        do_reset();
        Branch_taken = 1'b1;
        Branch_target = 32'h300;
        @(negedge clk);
        Branch_target = 32'h402;
        @(negedge clk);
        Branch_taken = 1'b0;
        chk("dd_hold_addr", imem_addr, 32'h0);
        chk("dd_hold_req", {31'd0, imem_req}, 32'd1);
        chk("dd_valid", {31'd0, id_valid}, 32'd0);
        wait_req_addr("dd_req400", 32'h400);
        wait_valid("dd_deliver");
        chk("dd_pc", PC_out, 32'h400);
        chk("dd_instr", Instr, 32'h1400);

        // Reset in the middle of a latency-4 request
        id_ready = 1'b0;
        lat = 4;
        @(negedge clk);
        chk("mr_pre_req", {31'd0, imem_req}, 32'd1);
        chk("mr_pre_valid", {31'd0, id_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_req", {31'd0, imem_req}, 32'd0);
        chk("mr_valid", {31'd0, id_valid}, 32'd0);
        chk("mr_instr", Instr, 32'd0);
        chk("mr_opcode", {26'd0, Opcode}, 32'd0);
        chk("mr_pc", PC_out, 32'd0);
        chk("mr_pc4", PC_plus4, 32'd4);
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        lat = 0;
        id_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("mr_restart_addr", imem_addr, 32'd0);
        chk("mr_restart_req", {31'd0, imem_req}, 32'd1);
        wait_valid("mr_deliver");
        chk("mr_first_pc", PC_out, 32'd0);
        chk("mr_first_instr", Instr, 32'h1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
